// File: rtl/control_fsm_pkg.sv
// Shared constants for the multicycle RV32I main controller: state codes,
// ALUOp codes and the opcode values the controller recognises.
package control_fsm_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        ALUWB    = 4'd7,
        EXECUTEI = 4'd8,
        JAL      = 4'd9,
        BEQ      = 4'd10
    } state_t;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;

    localparam logic [6:0] RType  = 7'b0110011;
    localparam logic [6:0] IType  = 7'b0010011;
    localparam logic [6:0] LWType = 7'b0000011;
    localparam logic [6:0] SType  = 7'b0100011;
    localparam logic [6:0] BType  = 7'b1100011;
    localparam logic [6:0] JType  = 7'b1101111;

    function automatic logic is_legal_op(input logic [6:0] op);
        return (op == RType) || (op == IType) || (op == LWType) ||
               (op == SType) || (op == BType) || (op == JType);
    endfunction

endpackage

// File: rtl/control_fsm.sv
// Multicycle main controller: steps the shared-memory datapath one state per
// cycle and drives its enables, mux selects and ALUOp from the current state.
module control_fsm
    import control_fsm_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [6:0]         op,
    input  logic               mem_ready,
    output logic               AdrSrc,
    output logic               IRWrite,
    output logic               PCUpdate,
    output logic               Branch,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic [2:0]         ALUOp,
    output logic               illegal_instr,
    output logic               instr_done,
    output logic [STATE_W-1:0] state
);

    // mem_ready is a level from memory meaning "the access presented this
    // cycle completes now"; FETCH, MEMREAD and MEMWRITE hold until it is seen.
    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:    state_d = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    LWType, SType: state_d = MEMADR;
                    RType:         state_d = EXECUTER;
                    IType:         state_d = EXECUTEI;
                    JType:         state_d = JAL;
                    BType:         state_d = BEQ;
                    default:       state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = (op == LWType) ? MEMREAD : MEMWRITE;
            MEMREAD:  state_d = mem_ready ? MEMWB : MEMREAD;
            MEMWB:    state_d = FETCH;
            MEMWRITE: state_d = mem_ready ? FETCH : MEMWRITE;
            EXECUTER: state_d = ALUWB;
            EXECUTEI: state_d = ALUWB;
            ALUWB:    state_d = FETCH;
            JAL:      state_d = ALUWB;
            BEQ:      state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    always_comb begin
        AdrSrc        = 1'b0;
        IRWrite       = 1'b0;
        PCUpdate      = 1'b0;
        Branch        = 1'b0;
        RegWrite      = 1'b0;
        MemWrite      = 1'b0;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 2'b00;
        ResultSrc     = 2'b00;
        ALUOp         = ALUOP_ADD;
        illegal_instr = 1'b0;
        instr_done    = 1'b0;
        case (state_q)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = mem_ready;
                PCUpdate  = mem_ready;
            end
            DECODE: begin
                ALUSrcA       = 2'b01;
                ALUSrcB       = 2'b01;
                illegal_instr = !is_legal_op(op);
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
            end
            MEMWB: begin
                ResultSrc  = 2'b01;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc     = 1'b1;
                MemWrite   = 1'b1;
                instr_done = mem_ready;
            end
            EXECUTER: begin
                ALUSrcA = 2'b10;
                ALUOp   = ALUOP_FUNCT;
            end
            EXECUTEI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ALUOp   = ALUOP_FUNCT;
            end
            ALUWB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                PCUpdate = 1'b1;
            end
            BEQ: begin
                ALUSrcA    = 2'b10;
                ALUOp      = ALUOP_SUB;
                Branch     = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        // Reset gates enables combinationally so nothing writes in the
        // same cycle reset rises, before the state register has cleared.
        if (reset) begin
            IRWrite       = 1'b0;
            PCUpdate      = 1'b0;
            Branch        = 1'b0;
            RegWrite      = 1'b0;
            MemWrite      = 1'b0;
            illegal_instr = 1'b0;
            instr_done    = 1'b0;
        end
    end

    assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: walks each instruction class through its
// state sequence and compares state plus the full output bundle every cycle.
module tb_control_fsm;

    logic       clk;
    logic       reset;
    logic [6:0] op;
    logic       mem_ready;
    logic       AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite;
    logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
    logic [2:0] ALUOp;
    logic       illegal_instr, instr_done;
    logic [3:0] state;
    logic [16:0] outs;

    int checks = 0;
    int errors = 0;

    // {AdrSrc,IRWrite,PCUpdate,Branch,RegWrite,MemWrite,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,illegal,done}
    localparam logic [16:0] E_FETCH_RDY  = 17'b0_1_1_0_0_0_00_10_10_000_0_0;
    localparam logic [16:0] E_FETCH_WAIT = 17'b0_0_0_0_0_0_00_10_10_000_0_0;
    localparam logic [16:0] E_RESET      = 17'b0_0_0_0_0_0_00_10_10_000_0_0;
    localparam logic [16:0] E_DECODE     = 17'b0_0_0_0_0_0_01_01_00_000_0_0;
    localparam logic [16:0] E_DECODE_ILL = 17'b0_0_0_0_0_0_01_01_00_000_1_0;
    localparam logic [16:0] E_MEMADR     = 17'b0_0_0_0_0_0_10_01_00_000_0_0;
    localparam logic [16:0] E_MEMREAD    = 17'b1_0_0_0_0_0_00_00_00_000_0_0;
    localparam logic [16:0] E_MEMWB      = 17'b0_0_0_0_1_0_00_00_01_000_0_1;
    localparam logic [16:0] E_MEMWR_WAIT = 17'b1_0_0_0_0_1_00_00_00_000_0_0;
    localparam logic [16:0] E_MEMWR_RDY  = 17'b1_0_0_0_0_1_00_00_00_000_0_1;
    localparam logic [16:0] E_EXR        = 17'b0_0_0_0_0_0_10_00_00_010_0_0;
    localparam logic [16:0] E_EXI        = 17'b0_0_0_0_0_0_10_01_00_010_0_0;
    localparam logic [16:0] E_ALUWB      = 17'b0_0_0_0_1_0_00_00_00_000_0_1;
    localparam logic [16:0] E_JAL        = 17'b0_0_1_0_0_0_01_10_00_000_0_0;
    localparam logic [16:0] E_BEQ        = 17'b0_0_0_1_0_0_10_00_00_001_0_1;

    control_fsm #(.STATE_W(4)) dut (
        .clk           (clk),
        .reset         (reset),
        .op            (op),
        .mem_ready     (mem_ready),
        .AdrSrc        (AdrSrc),
        .IRWrite       (IRWrite),
        .PCUpdate      (PCUpdate),
        .Branch        (Branch),
        .RegWrite      (RegWrite),
        .MemWrite      (MemWrite),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .ResultSrc     (ResultSrc),
        .ALUOp         (ALUOp),
        .illegal_instr (illegal_instr),
        .instr_done    (instr_done),
        .state         (state)
    );

    assign outs = {AdrSrc, IRWrite, PCUpdate, Branch, RegWrite, MemWrite,
                   ALUSrcA, ALUSrcB, ResultSrc, ALUOp, illegal_instr, instr_done};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply inputs for one cycle, check state and outputs, then advance.
    task automatic step(input string tag, input logic [6:0] op_i, input logic rdy_i,
                        input logic [3:0] exp_state, input logic [16:0] exp_outs);
        op = op_i;
        mem_ready = rdy_i;
        #1;
        check({tag, ".state"}, 32'(state), 32'(exp_state));
        check({tag, ".outs"}, 32'(outs), 32'(exp_outs));
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        op = 7'h00;
        mem_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst.state", 32'(state), 32'd0);
        check("rst.outs", 32'(outs), 32'(E_RESET));
        reset = 1'b0;

        // add x3,x1,x2
        step("add.f",  7'h33, 1'b1, 4'd0, E_FETCH_RDY);
        step("add.d",  7'h33, 1'b1, 4'd1, E_DECODE);
        step("add.ex", 7'h33, 1'b1, 4'd6, E_EXR);
        step("add.wb", 7'h33, 1'b1, 4'd7, E_ALUWB);

        // lw with two stall cycles in MEMREAD; op disturbed after MEMADR
        step("lw.f",   7'h03, 1'b1, 4'd0, E_FETCH_RDY);
        step("lw.d",   7'h03, 1'b1, 4'd1, E_DECODE);
        step("lw.a",   7'h03, 1'b1, 4'd2, E_MEMADR);
        step("lw.r0",  7'h23, 1'b0, 4'd3, E_MEMREAD);
        step("lw.r1",  7'h23, 1'b0, 4'd3, E_MEMREAD);
        step("lw.r2",  7'h03, 1'b1, 4'd3, E_MEMREAD);
        step("lw.wb",  7'h03, 1'b1, 4'd4, E_MEMWB);

        // sw with one stall cycle in MEMWRITE
        step("sw.f",   7'h23, 1'b1, 4'd0, E_FETCH_RDY);
        step("sw.d",   7'h23, 1'b1, 4'd1, E_DECODE);
        step("sw.a",   7'h23, 1'b1, 4'd2, E_MEMADR);
        step("sw.w0",  7'h23, 1'b0, 4'd5, E_MEMWR_WAIT);
        step("sw.w1",  7'h23, 1'b1, 4'd5, E_MEMWR_RDY);

        // beq, with a fetch stall first
        step("beq.fs", 7'h63, 1'b0, 4'd0, E_FETCH_WAIT);
        step("beq.f",  7'h63, 1'b1, 4'd0, E_FETCH_RDY);
        step("beq.d",  7'h63, 1'b1, 4'd1, E_DECODE);
        step("beq.b",  7'h63, 1'b1, 4'd10, E_BEQ);

        // jal
        step("jal.f",  7'h6F, 1'b1, 4'd0, E_FETCH_RDY);
        step("jal.d",  7'h6F, 1'b1, 4'd1, E_DECODE);
        step("jal.j",  7'h6F, 1'b1, 4'd9, E_JAL);
        step("jal.wb", 7'h6F, 1'b1, 4'd7, E_ALUWB);

        // addi; op changed in EXECUTEI must be ignored
        step("addi.f",  7'h13, 1'b1, 4'd0, E_FETCH_RDY);
        step("addi.d",  7'h13, 1'b1, 4'd1, E_DECODE);
        step("addi.ex", 7'h00, 1'b1, 4'd8, E_EXI);
        step("addi.wb", 7'h00, 1'b1, 4'd7, E_ALUWB);

        // illegal opcode: pulse for exactly one cycle
        step("ill.f",  7'h00, 1'b1, 4'd0, E_FETCH_RDY);
        step("ill.d",  7'h00, 1'b1, 4'd1, E_DECODE_ILL);
        step("ill.f2", 7'h00, 1'b0, 4'd0, E_FETCH_WAIT);

        // reset during a stalled store
        step("rsw.f",  7'h23, 1'b1, 4'd0, E_FETCH_RDY);
        step("rsw.d",  7'h23, 1'b1, 4'd1, E_DECODE);
        step("rsw.a",  7'h23, 1'b1, 4'd2, E_MEMADR);
        mem_ready = 1'b0;
        #1;
        check("rsw.pre_mw", 32'(MemWrite), 32'd1);
        reset = 1'b1;
        #1;
        check("rsw.state", 32'(state), 32'd0);
        check("rsw.outs", 32'(outs), 32'(E_RESET));
        mem_ready = 1'b1;
        #1;
        check("rsw.hold_outs", 32'(outs), 32'(E_RESET));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        step("post.f", 7'h33, 1'b1, 4'd0, E_FETCH_RDY);
        step("post.d", 7'h33, 1'b1, 4'd1, E_DECODE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_fsm.md
Name: control_fsm

Overview:
- Multicycle main controller for the RV32I core.
- Sequences the shared single-memory datapath through fetch, decode, execute, memory and writeback steps, one state per cycle.
- Drives the datapath enables and mux selects (AdrSrc, IRWrite, PCUpdate, RegWrite, MemWrite, Branch, ALUSrcA/B, ResultSrc) and the ALUOp handed to ALUdecoder.
- Stalls on a memory-ready handshake and flags illegal opcodes.

Parameters:
- STATE_W, 4, width of the state register and of the state debug port.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high; forces state to FETCH immediately.
- op  input  7  opcode field instr[6:0] from the instruction register.
- mem_ready  input  1  memory has completed the current access this cycle.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = Result.
- IRWrite  output  1  load the instruction register.
- PCUpdate  output  1  unconditional PC write.
- Branch  output  1  conditional PC write; datapath ANDs it with Zero.
- RegWrite  output  1  register file write enable.
- MemWrite  output  1  data memory write strobe.
- ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = rs1 data.
- ALUSrcB  output  2  00 = rs2 data, 01 = ImmExt, 10 = constant 4.
- ResultSrc  output  2  00 = ALUOut, 01 = read data, 10 = ALUResult.
- ALUOp  output  3  000 = add, 001 = subtract, 010 = decode from funct3/funct7.
- illegal_instr  output  1  one-cycle pulse on an unsupported opcode.
- instr_done  output  1  one-cycle pulse in the final state of each instruction.
- state  output  STATE_W  current state, for debug.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, ALUWB=7, EXECUTEI=8, JAL=9, BEQ=10. Codes 11-15 are unused and return to FETCH on the next clock.
- Reset: state=FETCH asynchronously. While reset=1, every write enable (IRWrite, PCUpdate, RegWrite, MemWrite, Branch) and both pulses are 0. Selects take their FETCH values.
- Output model: Moore decode of state. IRWrite, PCUpdate and MemWrite are additionally qualified by mem_ready as listed below. Every signal not listed for a state is 0.
- FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=000, ResultSrc=10. IRWrite=PCUpdate=mem_ready. Stay while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=000 (precomputes the branch/jump target). Next state by op:
  - LWType or SType -> MEMADR
  - RType -> EXECUTER
  - IType -> EXECUTEI
  - JType -> JAL
  - BType -> BEQ
  - anything else -> FETCH, with illegal_instr=1 this cycle.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=000. Go to MEMREAD if op=LWType, else MEMWRITE.
- MEMREAD: ResultSrc=00, AdrSrc=1. Stay until mem_ready=1, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done=1. Go to FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1, held high until mem_ready=1. On mem_ready=1: instr_done=1, go to FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=010. Go to ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=010. Go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_done=1. Go to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=000, ResultSrc=00, PCUpdate=1. Go to ALUWB (writes PC+4 to rd).
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=001, ResultSrc=00, Branch=1, instr_done=1. Go to FETCH.
- Latency in clocks, excluding stalls: R/I = 4, lw = 5, sw = 4, beq = 3, jal = 4, illegal = 2.
- op is sampled only in DECODE and MEMADR. Changes to op in other states have no effect.
- Reset asserted mid-instruction: abort immediately. No write enable may be seen high after reset rises, even within the same cycle.

Decomposition:
- params.vh gains the state codes (FETCH..BEQ) and the ALUOp codes (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT).
- params.vh already holds the opcode constants RType, IType, LWType, SType, BType and JType; reuse them.
- No sub-module: one sequential block for the state register, one combinational block each for next-state and outputs.

Test Plan:
- Reset held 3 cycles with mem_ready=1 -> state=0 and all enables 0. Release -> IRWrite=PCUpdate=1 in the first cycle.
- op=0x33 (add x3,x1,x2 = 0x002081B3), mem_ready=1 -> states 0,1,6,7,0. RegWrite=1 only in state 7. ALUOp=010 in state 6.
- lw 0x0080A283 with mem_ready=0 for 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0. RegWrite and ResultSrc=01 in state 4 only.
- sw 0x0050A223 with mem_ready low 1 cycle in MEMWRITE -> MemWrite high for 2 cycles. RegWrite never asserted. instr_done on the second MemWrite cycle.
- beq (op=0x63) -> states 0,1,10,0 with ALUOp=001 and Branch=1 in state 10. jal (op=0x6F) -> 0,1,9,7,0 with PCUpdate=1 in state 9.
- op=0x00 -> states 0,1,0 with illegal_instr=1 for exactly one cycle. Reset asserted during MEMWRITE with mem_ready=0 -> MemWrite drops with reset and state=0.
